// File: rtl/match_window_counter_pkg.sv
// Shared state encoding and default sizing for the match window counter.
package match_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int WIN_LEN_DEF = 16;
  localparam int CNT_W_DEF   = 8;
  localparam int THRESH_DEF  = 3;

endpackage

// File: rtl/match_window_counter_hit_accum.sv
// Hit accumulator: clearable CNT_W-bit counter; saturates when MATCH_CNT_SAT_EN is defined, else wraps.
// count_nxt exposes the value being loaded so the parent can judge the final hit of a window.
module hit_accum #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt
);

  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (inc) begin
`ifdef MATCH_CNT_SAT_EN
      if (count != '1) begin
        count_nxt = count + 1'b1;
      end
`else
      count_nxt = count + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/match_window_counter.sv
// Counts detector match pulses over a WIN_LEN-cycle window, then holds count/alarm until ack.
// Start-to-done latency WIN_LEN cycles; overflow mode chosen by MATCH_CNT_SAT_EN (see hit_accum).
module match_window_counter
  import match_pkg::*;
#(
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int THRESH  = THRESH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             hit,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             alarm
);

  localparam int               TMR_W    = $clog2(WIN_LEN);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESH);

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic             cnt_clr, cnt_inc, alarm_ld, alarm_clr;
  logic [CNT_W-1:0] cnt_nxt;

  hit_accum #(.CNT_W(CNT_W)) u_accum (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .count     (count),
    .count_nxt (cnt_nxt)
  );

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    alarm_ld  = 1'b0;
    alarm_clr = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = COUNT;
          cnt_clr   = 1'b1;
        end
      end
      COUNT: begin
        cnt_inc = hit;
        if (timer == TMR_LAST) begin
          state_nxt = REPORT;
          alarm_ld  = 1'b1;
        end
      end
      REPORT: begin
        if (ack) begin
          alarm_clr = 1'b1;
          if (start) begin
            state_nxt = COUNT;
            cnt_clr   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are flopped from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      timer <= '0;
      alarm <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == COUNT);
      done  <= (state_nxt == REPORT);
      if (cnt_clr) begin
        timer <= '0;
      end else if (state == COUNT) begin
        timer <= timer + TMR_W'(1);
      end
      if (alarm_clr) begin
        alarm <= 1'b0;
      end else if (alarm_ld) begin
        alarm <= (cnt_nxt >= THR);
      end
    end
  end

endmodule

// File: tb/tb_match_window_counter.sv
// Scoreboard bench for match_window_counter: default instance plus a narrow instance for overflow.
module tb_match_window_counter;

  localparam int WL  = 16;
  localparam int CW  = 8;
  localparam int TH  = 3;
  localparam int WL2 = 8;
  localparam int CW2 = 2;
  localparam int TH2 = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, hit = 1'b0, ack = 1'b0;
  logic          busy, done, alarm;
  logic [CW-1:0] count;
  logic           start2 = 1'b0, hit2 = 1'b0, ack2 = 1'b0;
  logic           busy2, done2, alarm2;
  logic [CW2-1:0] count2;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int cnt;
    bit alarm;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  match_window_counter #(.WIN_LEN(WL), .CNT_W(CW), .THRESH(TH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .ack(ack),
    .busy(busy), .done(done), .count(count), .alarm(alarm)
  );

  match_window_counter #(.WIN_LEN(WL2), .CNT_W(CW2), .THRESH(TH2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .hit(hit2), .ack(ack2),
    .busy(busy2), .done(done2), .count(count2), .alarm(alarm2)
  );

  task automatic test_reset();
    logic [10:0] obs;
    rst_n = 1'b0; start = 1'b1; hit = 1'b1; ack = 1'b0;
    repeat (3) @(negedge clk);
    obs = {busy, done, count, alarm};
    vectors++;
    if (obs !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_held: got %h expected %h", obs, 11'd0);
    end
    rst_n = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    hit = 1'b0;
    obs = {busy, done, count, alarm};
    vectors++;
    if (obs !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got %h expected %h", obs, 11'd0);
    end
  endtask

  // pat[0]: hit on the start edge, pat[1..WL]: window cycles, pat[WL+1]: one cycle after the window.
  task automatic run_window(input logic [WL+1:0] pat, input bit with_ack, input string name);
    int n;
    exp_t e;
    logic [10:0] obs, expv;
    @(negedge clk);
    n = 0;
    for (int i = 1; i <= WL; i++) n += int'(pat[i]);
    exp_q.push_back('{n, (n >= TH)});
    start = 1'b1; ack = with_ack; hit = pat[0];
    @(negedge clk);
    obs = {busy, done, count, alarm};
    expv = {1'b1, 1'b0, CW'(0), 1'b0};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s_open: got %h expected %h", name, obs, expv);
    end
    start = 1'b0; ack = 1'b0; hit = pat[1];
    for (int i = 2; i <= WL; i++) begin
      @(negedge clk);
      if (i == WL) begin
        obs = {busy, done, 9'd0};
        expv = {1'b1, 1'b0, 9'd0};
        vectors++;
        if (obs !== expv) begin
          miscompares++;
          $display("FAIL %s_not_early: got %h expected %h", name, obs, expv);
        end
      end
      hit = pat[i];
    end
    @(negedge clk);
    hit = pat[WL+1];
    e = exp_q.pop_front();
    obs = {busy, done, count, alarm};
    expv = {1'b0, 1'b1, CW'(e.cnt), e.alarm};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s_result: got %h expected %h", name, obs, expv);
    end
    @(negedge clk);
    hit = 1'b0;
    obs = {busy, done, count, alarm};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s_frozen: got %h expected %h", name, obs, expv);
    end
  endtask

  task automatic ack_to_idle(input int cnt, input string name);
    logic [10:0] obs, expv;
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    obs = {busy, done, count, alarm};
    expv = {1'b0, 1'b0, CW'(cnt), 1'b0};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s_ack: got %h expected %h", name, obs, expv);
    end
  endtask

  task automatic test_count_window();
    logic [WL+1:0] pat;
    pat = '0; pat[1] = 1'b1; pat[8] = 1'b1; pat[16] = 1'b1;
    run_window(pat, 1'b0, "three_hits");
    ack_to_idle(3, "three_hits");
    pat[16] = 1'b0;
    run_window(pat, 1'b0, "two_hits");
    ack_to_idle(2, "two_hits");
  endtask

  task automatic test_hit_edges();
    logic [WL+1:0] pat;
    pat = '0; pat[0] = 1'b1; pat[5] = 1'b1; pat[WL+1] = 1'b1;
    run_window(pat, 1'b0, "edge_hits");
    ack_to_idle(1, "edge_hits");
    pat = '1; pat[0] = 1'b0; pat[WL+1] = 1'b0;
    run_window(pat, 1'b0, "all_hits");
    ack_to_idle(16, "all_hits");
  endtask

  task automatic test_back_to_back();
    logic [WL+1:0] pat;
    logic [10:0] obs, expv;
    pat = '0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b1;
    run_window(pat, 1'b0, "b2b_first");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    obs = {busy, done, count, alarm};
    expv = {1'b0, 1'b1, CW'(3), 1'b1};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL start_without_ack: got %h expected %h", obs, expv);
    end
    pat = '0; pat[1] = 1'b1;
    run_window(pat, 1'b1, "b2b_second");
    ack_to_idle(1, "b2b_second");
  endtask

  task automatic test_overflow();
    int cnt;
    exp_t e;
    logic [4:0] obs, expv;
    @(negedge clk);
`ifdef MATCH_CNT_SAT_EN
    cnt = (WL2 > 3) ? 3 : WL2;
`else
    cnt = WL2 % 4;
`endif
    exp_q.push_back('{cnt, (cnt >= TH2)});
    start2 = 1'b1; hit2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (WL2) @(negedge clk);
    hit2 = 1'b0;
    e = exp_q.pop_front();
    obs = {busy2, done2, count2, alarm2};
    expv = {1'b0, 1'b1, CW2'(e.cnt), e.alarm};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL overflow: got %h expected %h", obs, expv);
    end
    ack2 = 1'b1;
    @(negedge clk);
    ack2 = 1'b0;
  endtask

  task automatic test_abort();
    logic [WL+1:0] pat;
    logic [10:0] obs, expv;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; hit = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    hit = 1'b0;
    obs = {busy, done, count, alarm};
    expv = {1'b1, 1'b0, CW'(4), 1'b0};
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL abort_partial: got %h expected %h", obs, expv);
    end
    rst_n = 1'b0;
    #1;
    obs = {busy, done, count, alarm};
    vectors++;
    if (obs !== 11'd0) begin
      miscompares++;
      $display("FAIL abort_reset: got %h expected %h", obs, 11'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pat = '0; pat[3] = 1'b1; pat[16] = 1'b1;
    run_window(pat, 1'b0, "restart");
    ack_to_idle(2, "restart");
  endtask

  initial begin
    test_reset();
    test_count_window();
    test_hit_edges();
    test_back_to_back();
    test_overflow();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/match_window_counter.md
# match_window_counter

Downstream consumer of the serial 1010 detector's one-cycle match pulse. Counts match pulses over a fixed window of `WIN_LEN` clock cycles started on request, then holds the result and a threshold alarm until acknowledged. Gives the control side a per-window hit count instead of raw single-cycle pulses.

## Interface
- `WIN_LEN`, 16: window length in clock cycles; legal range ≥ 2.
- `CNT_W`, 8: width of the hit counter.
- `THRESH`, 3: alarm threshold; legal range 1 .. 2^CNT_W−1.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a new window; sampled only in IDLE or REPORT.
- `hit`  in  1  match pulse from the detector's `q`; one hit per cycle at most.
- `ack`  in  1  consumer has read the result; sampled only in REPORT.
- `busy`  out  1  high while a window is in progress (COUNT).
- `done`  out  1  high while a result is held (REPORT).
- `count`  out  CNT_W  hits counted in the last or current window.
- `alarm`  out  1  `count >= THRESH`; valid only while `done`.

## Operation
- FSM states: IDLE, COUNT, REPORT. All outputs are registered.
- Reset value of every output: `busy=0`, `done=0`, `count=0`, `alarm=0`, state IDLE, timer 0.
- IDLE:
  - `hit` is ignored.
  - `start=1` → COUNT; `count` cleared to 0; timer cleared to 0.
- COUNT:
  - `hit=1` increments `count` every cycle it is sampled.
  - The timer increments every cycle.
  - When the timer is at `WIN_LEN−1` on an edge, that edge's hit is still counted; state → REPORT.
  - `alarm` is loaded from the final count, including that last hit.
  - `start` and `ack` are ignored.
- REPORT:
  - `count` and `alarm` are frozen; `hit` is ignored.
  - `ack=1`, `start=0` → IDLE; `alarm` cleared; `count` holds its value.
  - `ack=1`, `start=1` → COUNT directly (back-to-back window); `count` and timer cleared; `alarm` cleared.
  - `start=1` without `ack` is ignored.
- Timer width is `$clog2(WIN_LEN)`. Timer compare is exact equality; no wrap inside a window.
- Counter arithmetic is unsigned, CNT_W bits. Overflow behaviour is set by the macro in Configuration.
- Asserting `rst_n` low mid-window aborts the window immediately. Partial counts are discarded.

## Timing
- `start` is sampled at edge k. The window covers `hit` sampled at edges k+1 … k+WIN_LEN.
- `busy` is high from after edge k until edge k+WIN_LEN.
- `done` and `alarm` are valid after edge k+WIN_LEN.
- Latency from start to done is WIN_LEN cycles. No combinational path from any input to any output.
- `done` falls on the edge that samples `ack`.
- With start+ack together, `busy` rises on that same edge; zero idle cycles between windows.
- `hit` is a single-cycle pulse from the same clock domain; no synchroniser is needed.

## Configuration
- `MATCH_CNT_SAT_EN` defined:
  - `count` saturates at 2^CNT_W−1 and further hits are dropped.
  - `alarm` stays correct for any hit total.
- `MATCH_CNT_SAT_EN` not defined:
  - `count` wraps modulo 2^CNT_W.
  - `alarm` compares the wrapped value, so it may read 0 after heavy traffic.
  - Integrators must size `CNT_W > $clog2(WIN_LEN)` to avoid wrap.

## Structure
- Package `match_pkg` holds:
  - the state typedef: 2-bit enum IDLE=0, COUNT=1, REPORT=2;
  - default constants for `WIN_LEN`, `CNT_W` and `THRESH`.
- One sub-module, `hit_accum`:
  - CNT_W-bit counter with clear, increment enable and saturate/wrap select;
  - the `MATCH_CNT_SAT_EN` branch lives only in this sub-module.
- Top level holds the FSM, the window timer and the alarm register.

## Test plan
1. Reset → IDLE with `rst_n=0` while `start=1` and `hit=1`: all outputs 0 and `busy=0`. Release reset: outputs stay 0 until `start`.
2. Window with 3 hits (default params): `start` pulse, then hits at window cycles 1, 8 and 16 → `done=1` exactly 16 cycles after the start edge; `count=3`, `alarm=1`. Same stimulus with 2 hits → `count=2`, `alarm=0`.
3. Hit edges: `hit=1` on the start edge and one cycle after the last window edge → neither is counted. `hit=1` for all 16 window cycles → `count=16`.
4. Back-to-back windows: in REPORT, drive `ack=1` and `start=1` together → `done` drops and `busy` rises on the same edge. The new window starts at `count=0`; `start` alone in REPORT is ignored.
5. Overflow with `CNT_W=2`, `WIN_LEN=8`, `THRESH=3`, `hit` held high:
   - `MATCH_CNT_SAT_EN` defined → `count=3`, `alarm=1`;
   - undefined → `count=0`, `alarm=0`.
6. Abort: drop `rst_n` at window cycle 5 with 4 hits counted → all outputs 0 immediately. Restart gives a clean 16-cycle window.
